button_conditioner: RTL
=======================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL take parameter N_CH, default 4: number of independent button channels, 1..16.
REQ-002 SHALL take parameter DELAY, default 20000: number of consecutive disagreeing samples needed to accept a level change, 1..2^24-1.
REQ-003 SHALL take parameter ACTIVE_LOW, default 1: 1 means a pin is idle high and pressed low.
REQ-004 SHALL take parameter REPEAT_START, default 0: cycles from press to the first auto-repeat pulse; 0 disables auto-repeat.
REQ-005 SHALL take parameter REPEAT_PERIOD, default 5000000: cycles between later auto-repeat pulses, at least 1.
REQ-006 SHALL have port clk_i, input, width 1: the single clock.
REQ-007 SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-008 SHALL have port btn_i, input, width N_CH: raw asynchronous button pins.
REQ-009 SHALL have port level_o, output, width N_CH: debounced logical level, 1 = pressed.
REQ-010 SHALL have port press_o, output, width N_CH: one-cycle pulse on an accepted press.
REQ-011 SHALL have port release_o, output, width N_CH: one-cycle pulse on an accepted release.
REQ-012 SHALL have port repeat_o, output, width N_CH: one-cycle auto-repeat pulse while held.
REQ-013 SHALL have port any_press_o, output, width 1: OR of press_o.

Function
REQ-014 SHALL pass each btn_i bit through a 2-flop synchronizer, then XOR it with ACTIVE_LOW to form the logical sample.
REQ-015 SHALL run a per-channel FSM with states RELEASED, PRESS_PEND, PRESSED and RELEASE_PEND.
REQ-016 SHALL move RELEASED->PRESS_PEND on sample=1, and PRESSED->RELEASE_PEND on sample=0; the counter SHALL be cleared on entry.
REQ-017 SHALL, in a PEND state, increment the counter on each disagreeing sample; the first agreeing sample SHALL return the FSM to its prior stable state and clear the counter.
REQ-018 SHALL move PRESS_PEND->PRESSED or RELEASE_PEND->RELEASED when the counter reaches DELAY, clearing the counter; this is DELAY consecutive samples.
REQ-019 SHALL hold level_o[i]=1 exactly while the FSM is in PRESSED or RELEASE_PEND.
REQ-020 SHALL set input-to-level_o latency to DELAY+2 clock edges for a clean input edge.
REQ-021 SHALL make press_o[i] high only in the first cycle level_o[i]=1, and release_o[i] high only in the first cycle level_o[i]=0 after a press; outputs SHALL be registered.
REQ-022 SHALL, when REPEAT_START>0, pulse repeat_o[i] exactly REPEAT_START cycles after press_o[i], then every REPEAT_PERIOD cycles while level_o[i]=1.
REQ-023 SHALL stop the repeat sequence in the cycle level_o[i] falls; a new press SHALL restart the sequence from REPEAT_START.
REQ-024 SHALL never assert press_o[i] and repeat_o[i] in the same cycle.
REQ-025 SHALL operate channels fully independently; simultaneous events on any channels SHALL produce simultaneous pulses.
REQ-026 SHALL size counters with $clog2(max+1); counters SHALL never wrap, since each is cleared or reloaded before overflow.

Reset
REQ-027 SHALL, on reset, set all FSMs to RELEASED, clear all counters and synchronizer flops to the idle pin value (ACTIVE_LOW), and drive all outputs to 0.
REQ-028 SHALL discard any pending debounce or repeat sequence when reset is asserted mid-operation, with no pulse on deassertion.
REQ-029 SHALL, after reset deasserts with a pin held pressed, require the full DELAY+2 latency before press_o fires.

Structure
REQ-030 SHALL place the FSM state enum btn_state_t and default constants (DEF_DELAY, DEF_N_CH) in package button_pkg.
REQ-031 SHALL instantiate one sub-module button_channel per channel, containing the synchronizer, FSM, debounce counter and repeat counter; the top level SHALL be a generate loop plus the any_press_o OR.

Verification
Use parameters N_CH=4, DELAY=4, ACTIVE_LOW=1, REPEAT_START=10, REPEAT_PERIOD=5.
REQ-032 SHALL check: reset asserted with btn_i=4'hF -> all outputs 0; after release, with no input change for 50 cycles -> all outputs stay 0.
REQ-033 SHALL check: btn_i[0] low for 3 cycles, then high -> level_o[0], press_o[0] and release_o[0] never assert.
REQ-034 SHALL check: btn_i[1] low and held -> level_o[1] rises at edge 6 after the change; press_o[1] and any_press_o are high for that one cycle only.
REQ-035 SHALL check: btn_i[1] held 28 cycles past press_o -> repeat_o[1] pulses at +10, +15, +20 and +25; on release, release_o[1] pulses at edge 6 and no further repeats occur.
REQ-036 SHALL check: btn_i[3:2] low in the same cycle -> press_o[2] and press_o[3] in the same cycle; an 8-cycle bounce on btn_i[3] then release leaves channel 2 unaffected.
REQ-037 SHALL check: reset pulsed while channel 0 is in PRESS_PEND with counter=3 -> no press_o; the counter restarts from 0 after reset deasserts.

Source files
------------

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared state type, defaults and helpers for the button conditioner
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_state_t;

  localparam int DEF_DELAY         = 20000;
  localparam int DEF_N_CH          = 4;
  localparam int DEF_REPEAT_PERIOD = 5000000;

  // Width needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // The debounced level stays high while a release is still being qualified.
  function automatic logic is_level(input btn_state_t s);
    return (s == PRESSED) || (s == RELEASE_PEND);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - raw pin in, conditioned level and event pulses out
interface button_conditioner_if #(
  parameter int W = 1
);

  logic [W-1:0] btn;
  logic [W-1:0] level;
  logic [W-1:0] press;
  logic [W-1:0] rls;
  logic [W-1:0] rpt;

  modport master (
    input  btn,
    output level,
    output press,
    output rls,
    output rpt
  );

  modport slave (
    output btn,
    input  level,
    input  press,
    input  rls,
    input  rpt
  );

endinterface

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one button: synchronizer, debounce FSM, edge pulses and auto-repeat
module button_channel
  import button_pkg::*;
#(
  parameter int DELAY         = DEF_DELAY,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int REPEAT_START  = 0,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input logic                  clk_i,
  input logic                  reset,
  button_conditioner_if.master ch
);

  localparam int RPT_MAX = (REPEAT_START > REPEAT_PERIOD) ? REPEAT_START : REPEAT_PERIOD;
  localparam int CW      = cnt_width(DELAY);
  localparam int RW      = cnt_width(RPT_MAX);

  // The sample that opens a pending window is the first of the DELAY, so the
  // counter only has to see DELAY-1 further agreeing samples.
  localparam logic [CW-1:0] DEB_LAST  = CW'(DELAY - 1);
  localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_START);
  localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_PERIOD);

  logic          sync1_q;
  logic          sync2_q;
  logic          sample;

  btn_state_t    state_q;
  btn_state_t    state_d;
  logic [CW-1:0] deb_cnt_q;
  logic [CW-1:0] deb_cnt_d;
  logic [CW-1:0] deb_inc;

  logic          level_cur;
  logic          level_d;
  logic          press_q;
  logic          press_d;
  logic          rls_q;
  logic          rls_d;

  logic [RW-1:0] rpt_cnt_q;
  logic [RW-1:0] rpt_cnt_d;
  logic [RW-1:0] rpt_inc;
  logic          rpt_first_q;
  logic          rpt_first_d;
  logic          rpt_q;
  logic          rpt_d;

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      sync1_q <= ACTIVE_LOW;
      sync2_q <= ACTIVE_LOW;
    end else begin
      sync1_q <= ch.btn[0];
      sync2_q <= sync1_q;
    end
  end

  assign sample  = sync2_q ^ ACTIVE_LOW;
  assign deb_inc = deb_cnt_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    case (state_q)
      RELEASED: begin
        if (sample) begin
          state_d   = (DELAY == 1) ? PRESSED : PRESS_PEND;
          deb_cnt_d = '0;
        end
      end
      PRESS_PEND: begin
        if (!sample) begin
          state_d   = RELEASED;
          deb_cnt_d = '0;
        end else if (deb_inc == DEB_LAST) begin
          state_d   = PRESSED;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end
      PRESSED: begin
        if (!sample) begin
          state_d   = (DELAY == 1) ? RELEASED : RELEASE_PEND;
          deb_cnt_d = '0;
        end
      end
      RELEASE_PEND: begin
        if (sample) begin
          state_d   = PRESSED;
          deb_cnt_d = '0;
        end else if (deb_inc == DEB_LAST) begin
          state_d   = RELEASED;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end
      default: begin
        state_d   = RELEASED;
        deb_cnt_d = '0;
      end
    endcase
  end

  assign level_cur = is_level(state_q);
  assign level_d   = is_level(state_d);
  assign press_d   = level_d & ~level_cur;
  assign rls_d     = level_cur & ~level_d;
  assign rpt_inc   = rpt_cnt_q + RW'(1);

  // Repeat timer counts cycles since the press pulse, then since the last repeat.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    rpt_d       = 1'b0;
    if (!level_d || press_d) begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
    end else if (REPEAT_START > 0) begin
      if (rpt_inc == (rpt_first_q ? RPT_FIRST : RPT_NEXT)) begin
        rpt_d       = 1'b1;
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b0;
      end else begin
        rpt_cnt_d = rpt_inc;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q     <= RELEASED;
      deb_cnt_q   <= '0;
      press_q     <= 1'b0;
      rls_q       <= 1'b0;
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
      rpt_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      press_q     <= press_d;
      rls_q       <= rls_d;
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
      rpt_q       <= rpt_d;
    end
  end

  assign ch.level = level_cur;
  assign ch.press = press_q;
  assign ch.rls   = rls_q;
  assign ch.rpt   = rpt_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - N_CH independent debounced buttons with press/release/repeat pulses
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_CH          = DEF_N_CH,
  parameter int DELAY         = DEF_DELAY,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int REPEAT_START  = 0,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic            clk_i,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] repeat_o,
  output logic            any_press_o
);

  genvar i;
  generate
    for (i = 0; i < N_CH; i++) begin : g_ch
      button_conditioner_if #(.W(1)) ch_if ();

      assign ch_if.btn    = btn_i[i];
      assign level_o[i]   = ch_if.level;
      assign press_o[i]   = ch_if.press;
      assign release_o[i] = ch_if.rls;
      assign repeat_o[i]  = ch_if.rpt;

      button_channel #(
        .DELAY         (DELAY),
        .ACTIVE_LOW    (ACTIVE_LOW),
        .REPEAT_START  (REPEAT_START),
        .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_chan (
        .clk_i (clk_i),
        .reset (reset),
        .ch    (ch_if)
      );
    end
  endgenerate

  assign any_press_o = |press_o;

endmodule
